// File: rtl/fc1_sequencer.sv
// fc1_sequencer: control FSM that sequences one fc1 inference pass over all input features.
// Optional performance counters are built only when FC1_SEQ_PERF_CNT_EN is defined.
module fc1_sequencer #(
   parameter int unsigned NUM_INPUTS = 784,
   parameter int unsigned ADDR_WIDTH = $clog2(784),
   parameter int unsigned RD_LATENCY = 1,
   parameter int unsigned PERF_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  stall,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] feat_addr,
   output logic                  addr_valid,
   output logic                  pipe_en,
   output logic                  mac_clear,
   output logic                  mac_en,
   output logic                  mac_last,
   output logic                  result_valid,
   input  logic                  result_ready,
   output logic [PERF_WIDTH-1:0] perf_cycles,
   output logic [PERF_WIDTH-1:0] perf_stalls
);

   typedef enum logic [2:0] {StIdle, StClear, StRun, StDrain, StResult} state_e;

   localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(NUM_INPUTS - 1);

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
   logic                  done_q, done_d;
   logic [RD_LATENCY-1:0] vld_q, last_q;
   logic [RD_LATENCY:0]   vld_sh, last_sh;
   logic                  is_last;

   assign is_last = (cnt_q == LastAddr);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      case (state_q)
         StIdle: begin
            if (start) state_d = StClear;
         end
         StClear: begin
            cnt_d   = '0;
            state_d = StRun;
         end
         StRun: begin
            // Counter holds on the last address so it never wraps.
            if (!stall) begin
               if (is_last) state_d = StDrain;
               else         cnt_d   = cnt_q + ADDR_WIDTH'(1);
            end
         end
         StDrain: begin
            if (mac_last) state_d = StResult;
         end
         StResult: begin
            if (result_ready) begin
               state_d = StIdle;
               done_d  = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Read-latency delay line; frozen together with the external read pipeline.
   assign vld_sh  = {vld_q, addr_valid};
   assign last_sh = {last_q, is_last};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q  <= '0;
         last_q <= '0;
      end else if (!stall) begin
         vld_q  <= vld_sh[RD_LATENCY-1:0];
         last_q <= last_sh[RD_LATENCY-1:0];
      end
   end

   assign busy         = (state_q != StIdle);
   assign addr_valid   = (state_q == StRun);
   assign mac_clear    = (state_q == StClear);
   assign result_valid = (state_q == StResult);
   assign feat_addr    = cnt_q;
   assign done         = done_q;
   assign pipe_en      = !stall;
   assign mac_en       = vld_q[RD_LATENCY-1] & !stall;
   assign mac_last     = mac_en & last_q[RD_LATENCY-1];

`ifdef FC1_SEQ_PERF_CNT_EN
   logic [PERF_WIDTH-1:0] perf_cyc_q, perf_stl_q;
   logic                  stall_cnt;

   assign stall_cnt = stall && ((state_q == StRun) || (state_q == StDrain));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_cyc_q <= '0;
         perf_stl_q <= '0;
      end else if (state_q == StIdle) begin
         if (start) begin
            perf_cyc_q <= '0;
            perf_stl_q <= '0;
         end
      end else begin
         if (~&perf_cyc_q)             perf_cyc_q <= perf_cyc_q + PERF_WIDTH'(1);
         if (stall_cnt && ~&perf_stl_q) perf_stl_q <= perf_stl_q + PERF_WIDTH'(1);
      end
   end

   assign perf_cycles = perf_cyc_q;
   assign perf_stalls = perf_stl_q;
`else
   assign perf_cycles = '0;
   assign perf_stalls = '0;
`endif

endmodule

// File: tb/tb_fc1_sequencer.sv
// Directed self-checking bench for fc1_sequencer (RD_LATENCY=1 and RD_LATENCY=3 instances).
`timescale 1ns/1ps
module tb_fc1_sequencer;
   localparam int unsigned N  = 784;
   localparam int unsigned AW = $clog2(784);
   localparam int unsigned PW = 32;
`ifdef FC1_SEQ_PERF_CNT_EN
   localparam bit PerfOn = 1'b1;
`else
   localparam bit PerfOn = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst, start, start3, stall, result_ready;

   logic          busy, done, addr_valid, pipe_en, mac_clear, mac_en, mac_last, result_valid;
   logic [AW-1:0] feat_addr;
   logic [PW-1:0] perf_cycles, perf_stalls;
   logic          busy3, done3, addr_valid3, pipe_en3, mac_clear3, mac_en3, mac_last3;
   logic          result_valid3;
   logic [AW-1:0] feat_addr3;
   logic [PW-1:0] perf_cycles3, perf_stalls3;

   fc1_sequencer #(.NUM_INPUTS(N), .ADDR_WIDTH(AW), .RD_LATENCY(1), .PERF_WIDTH(PW)) u_dut (
      .clk(clk), .rst(rst), .start(start), .stall(stall), .busy(busy), .done(done),
      .feat_addr(feat_addr), .addr_valid(addr_valid), .pipe_en(pipe_en), .mac_clear(mac_clear),
      .mac_en(mac_en), .mac_last(mac_last), .result_valid(result_valid),
      .result_ready(result_ready), .perf_cycles(perf_cycles), .perf_stalls(perf_stalls)
   );

   fc1_sequencer #(.NUM_INPUTS(N), .ADDR_WIDTH(AW), .RD_LATENCY(3), .PERF_WIDTH(PW)) u_dut3 (
      .clk(clk), .rst(rst), .start(start3), .stall(stall), .busy(busy3), .done(done3),
      .feat_addr(feat_addr3), .addr_valid(addr_valid3), .pipe_en(pipe_en3),
      .mac_clear(mac_clear3), .mac_en(mac_en3), .mac_last(mac_last3),
      .result_valid(result_valid3), .result_ready(result_ready),
      .perf_cycles(perf_cycles3), .perf_stalls(perf_stalls3)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor selects which instance it observes.
   bit sel = 1'b0;
   logic          m_busy, m_done, m_av, m_clr, m_en, m_last, m_rv;
   logic [AW-1:0] m_addr;
   assign m_busy = sel ? busy3 : busy;
   assign m_done = sel ? done3 : done;
   assign m_av   = sel ? addr_valid3 : addr_valid;
   assign m_clr  = sel ? mac_clear3 : mac_clear;
   assign m_en   = sel ? mac_en3 : mac_en;
   assign m_last = sel ? mac_last3 : mac_last;
   assign m_rv   = sel ? result_valid3 : result_valid;
   assign m_addr = sel ? feat_addr3 : feat_addr;

   int n_cmp = 0, n_bad = 0;

   task automatic check(input string tag, input longint got, input longint exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   int n_clear, clear_cyc, first_addr_cyc, last_addr_cyc, exp_addr, addr_err, n_addr100;
   int n_mac, first_mac_cyc, n_mac_stall, n_last, last_cyc, last_err;
   int rv_cyc, n_rv_busy, n_done, done_cyc, n_drain;

   task automatic mon_clear();
      n_clear = 0; clear_cyc = -1; first_addr_cyc = -1; last_addr_cyc = -1; exp_addr = 0;
      addr_err = 0; n_addr100 = 0; n_mac = 0; first_mac_cyc = -1; n_mac_stall = 0;
      n_last = 0; last_cyc = -1; last_err = 0; rv_cyc = -1; n_rv_busy = 0; n_done = 0;
      done_cyc = -1; n_drain = 0;
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (m_clr) begin
            n_clear++; clear_cyc = cyc; exp_addr = 0;
         end
         if (m_av) begin
            if (first_addr_cyc < 0) first_addr_cyc = cyc;
            last_addr_cyc = cyc;
            if (int'(m_addr) != exp_addr) addr_err++;
            if (int'(m_addr) == 100) n_addr100++;
            if (!stall) exp_addr++;
         end
         if (m_en) begin
            n_mac++;
            if (first_mac_cyc < 0) first_mac_cyc = cyc;
            if (stall) n_mac_stall++;
         end
         if (m_last) begin
            n_last++; last_cyc = cyc;
            if (!m_en || (n_mac % N) != 0) last_err++;
         end
         if (m_rv) begin
            if (rv_cyc < 0) rv_cyc = cyc;
            if (m_busy) n_rv_busy++;
         end
         if (m_done) begin
            n_done++; done_cyc = cyc;
         end
         if (m_busy && !m_av && !m_rv && !m_clr) n_drain++;
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic do_start(input bit which, output int t);
      step();
      if (which) start3 = 1'b1; else start = 1'b1;
      t = cyc;
      step();
      start = 1'b0; start3 = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (m_busy && n < 3000) begin step(); n++; end
      repeat (3) step();
   endtask

   task automatic wait_addr(input int a);
      int n = 0;
      while (!(addr_valid && int'(feat_addr) == a) && n < 3000) begin step(); n++; end
   endtask

   task automatic wait_rv();
      int n = 0;
      while (!m_rv && n < 3000) begin step(); n++; end
   endtask

   task automatic wait_done();
      int n = 0;
      while (!m_done && n < 3000) begin step(); n++; end
   endtask

   task automatic wait_drain();
      int n = 0;
      while (!(m_busy && !m_av && !m_rv && !m_clr) && n < 3000) begin step(); n++; end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got time %0t, expected completion", $time);
      $fatal(1, "bench timed out");
   end

   int t, d, r;

   initial begin
      rst = 1'b1; start = 1'b0; start3 = 1'b0; stall = 1'b0; result_ready = 1'b1;
      mon_clear();
      repeat (3) step();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_addr_valid", addr_valid, 0);
      check("rst_feat_addr", feat_addr, 0);
      check("rst_mac_clear", mac_clear, 0);
      check("rst_mac_en", mac_en, 0);
      check("rst_mac_last", mac_last, 0);
      check("rst_result_valid", result_valid, 0);
      check("rst_perf_cycles", perf_cycles, 0);
      check("rst_perf_stalls", perf_stalls, 0);
      check("rst_pipe_en_nostall", pipe_en, 1);
      stall = 1'b1; #1;
      check("rst_pipe_en_stall", pipe_en, 0);
      check("rst_pipe_en3_stall", pipe_en3, 0);
      stall = 1'b0;
      step();
      rst = 1'b0;
      repeat (2) step();

      // Stall-free pass
      mon_clear();
      do_start(1'b0, t);
      wait_idle();
      check("p1_clear_cyc", clear_cyc - t, 1);
      check("p1_n_clear", n_clear, 1);
      check("p1_first_addr", first_addr_cyc - t, 2);
      check("p1_last_addr", last_addr_cyc - t, 785);
      check("p1_addr_err", addr_err, 0);
      check("p1_n_mac", n_mac, 784);
      check("p1_first_mac", first_mac_cyc - t, 3);
      check("p1_mac_last_cyc", last_cyc - t, 786);
      check("p1_n_last", n_last, 1);
      check("p1_last_err", last_err, 0);
      check("p1_rv_cyc", rv_cyc - t, 787);
      check("p1_done_cyc", done_cyc - t, 788);
      check("p1_n_done", n_done, 1);
      check("p1_perf_cycles", perf_cycles, PerfOn ? 787 : 0);
      check("p1_perf_stalls", perf_stalls, 0);

      // Stall injection at address 100 and in DRAIN
      mon_clear();
      do_start(1'b0, t);
      wait_addr(100);
      stall = 1'b1;
      repeat (5) step();
      stall = 1'b0;
      wait_drain();
      stall = 1'b1;
      repeat (3) step();
      stall = 1'b0;
      wait_idle();
      check("st_addr100_hold", n_addr100, 6);
      check("st_addr_err", addr_err, 0);
      check("st_n_mac", n_mac, 784);
      check("st_mac_while_stall", n_mac_stall, 0);
      check("st_n_last", n_last, 1);
      check("st_drain_cycles", n_drain, 4);
      check("st_rv_cyc", rv_cyc - t, 795);
      check("st_perf_cycles", perf_cycles, PerfOn ? 795 : 0);
      check("st_perf_stalls", perf_stalls, PerfOn ? 8 : 0);

      // Result back-pressure
      result_ready = 1'b0;
      mon_clear();
      do_start(1'b0, t);
      wait_rv();
      repeat (20) step();
      result_ready = 1'b1;
      r = cyc;
      wait_idle();
      check("bp_rv_cyc", rv_cyc - t, 787);
      check("bp_rv_busy_cycles", n_rv_busy, 21);
      check("bp_n_done", n_done, 1);
      check("bp_done_cyc", done_cyc - r, 1);
      check("bp_perf_cycles", perf_cycles, PerfOn ? 807 : 0);

      // Start during RUN ignored; start in the done cycle accepted
      mon_clear();
      do_start(1'b0, t);
      wait_addr(300);
      start = 1'b1;
      step();
      start = 1'b0;
      wait_done();
      d = cyc;
      start = 1'b1;
      check("b2b_first_n_clear", n_clear, 1);
      check("b2b_first_rv", rv_cyc - t, 787);
      step();
      start = 1'b0;
      wait_idle();
      check("b2b_clear_cyc", clear_cyc - d, 1);
      check("b2b_n_clear", n_clear, 2);
      check("b2b_n_mac", n_mac, 1568);
      check("b2b_n_done", n_done, 2);
      check("b2b_addr_err", addr_err, 0);

      // Reset mid-pass
      mon_clear();
      do_start(1'b0, t);
      wait_addr(400);
      rst = 1'b1;
      #1;
      check("mr_busy", busy, 0);
      check("mr_addr_valid", addr_valid, 0);
      check("mr_feat_addr", feat_addr, 0);
      check("mr_mac_en", mac_en, 0);
      check("mr_mac_last", mac_last, 0);
      check("mr_result_valid", result_valid, 0);
      check("mr_done", done, 0);
      check("mr_perf_cycles", perf_cycles, 0);
      repeat (3) step();
      rst = 1'b0;
      mon_clear();
      repeat (5) step();
      check("mr_no_done", n_done, 0);
      check("mr_no_busy", busy, 0);
      do_start(1'b0, t);
      wait_idle();
      check("mr_pass_n_mac", n_mac, 784);
      check("mr_pass_addr_err", addr_err, 0);
      check("mr_pass_last_addr", last_addr_cyc - t, 785);
      check("mr_pass_rv", rv_cyc - t, 787);
      check("mr_pass_n_done", n_done, 1);

      // RD_LATENCY = 3 instance
      sel = 1'b1;
      step();
      mon_clear();
      do_start(1'b1, t);
      wait_idle();
      check("l3_first_mac", first_mac_cyc - t, 5);
      check("l3_n_mac", n_mac, 784);
      check("l3_mac_last_cyc", last_cyc - t, 788);
      check("l3_last_err", last_err, 0);
      check("l3_drain_cycles", n_drain, 3);
      check("l3_rv_cyc", rv_cyc - t, 789);
      check("l3_n_done", n_done, 1);
      check("l3_perf_cycles", perf_cycles3, PerfOn ? 789 : 0);
      check("l3_perf_stalls", perf_stalls3, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fc1_sequencer.md
# fc1_sequencer

Control FSM for the fc1 fully-connected layer. It sequences one inference pass over all input features. Each cycle it drives one shared feature address to the activation buffer and to the fc1 weight ROM, which returns all 16 neuron weights for that feature packed into one word. It aligns the MAC-array enables to the read latency, honours back-pressure from the MAC array, and hands the finished accumulator bank downstream with a valid/ready handshake.

## Interface
Parameters:
- NUM_INPUTS, 784, number of input features (ROM rows) per pass
- ADDR_WIDTH, $clog2(784), width of feat_addr
- RD_LATENCY, 1, cycles from feat_addr to data valid at the MAC inputs (≥1)
- PERF_WIDTH, 32, width of the performance counters

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a pass; sampled only in IDLE
- stall  in  1  MAC array back-pressure; freezes the sequencer
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the result handshake
- feat_addr  out  ADDR_WIDTH  feature index to the activation buffer and weight ROM
- addr_valid  out  1  feat_addr is a live read this cycle
- pipe_en  out  1  = !stall; enables the read pipeline registers outside this block
- mac_clear  out  1  clear all accumulators (one cycle)
- mac_en  out  1  MAC array accumulates this cycle
- mac_last  out  1  qualifies the final mac_en of the pass
- result_valid  out  1  accumulators hold the final pass result
- result_ready  in  1  downstream accepts the result
- perf_cycles  out  PERF_WIDTH  busy cycles in the last pass
- perf_stalls  out  PERF_WIDTH  stalled cycles in the last pass

## Operation
- States: IDLE → CLEAR → RUN → DRAIN → RESULT → IDLE.
- **IDLE:** start=1 → CLEAR. start is ignored in every other state.
- **CLEAR:** one cycle, mac_clear=1, address counter set to 0. Next state is RUN, unconditionally; stall is ignored here.
- **RUN:** addr_valid=1 and feat_addr=counter.
  - Counter increments only when !stall.
  - When counter=NUM_INPUTS-1 and !stall → DRAIN.
  - The counter never wraps.
- **Valid delay line:** RD_LATENCY stages carrying addr_valid and a last flag (counter=NUM_INPUTS-1).
  - Shifts only when !stall.
  - mac_en = stage-out valid & !stall.
  - mac_last = mac_en & stage-out last.
- **DRAIN:** addr_valid=0. Leaves for RESULT in the cycle mac_last=1.
- **RESULT:** result_valid=1, held until result_ready=1.
  - Handshake cycle → IDLE, with done=1 in the following cycle.
  - stall has no effect in RESULT.
- A start in the cycle done=1 (state IDLE) is accepted normally.
- Reset mid-pass aborts immediately. Everything returns to IDLE with no done and no result_valid.

## Timing
- Reset values:
  - state=IDLE, counter=0, delay line empty.
  - busy, done, addr_valid, mac_clear, mac_en, mac_last, result_valid all 0.
  - feat_addr=0, perf counters=0.
  - pipe_en=!stall (combinational).
- All outputs are registered or decoded from registered state, except pipe_en, mac_en and mac_last, which are combinational on stall.
- Stall-free pass, start sampled at cycle t:
  - mac_clear at t+1.
  - feat_addr 0..NUM_INPUTS-1 on t+2..t+NUM_INPUTS+1.
  - mac_en on t+2+RD_LATENCY.. through t+NUM_INPUTS+1+RD_LATENCY, with mac_last on the final cycle.
  - result_valid from t+NUM_INPUTS+2+RD_LATENCY.
- Each stall cycle adds exactly one cycle of latency; no enable is lost or duplicated.
- Exactly NUM_INPUTS mac_en pulses per pass, in address order.

## Configuration
- Macro: FC1_SEQ_PERF_CNT_EN.
- **Defined:**
  - perf_cycles counts busy cycles.
  - perf_stalls counts cycles with busy & stall in RUN or DRAIN.
  - Both clear on start acceptance, freeze in IDLE, and saturate at all-ones.
- **Undefined:** both ports are tied to 0 and no counter logic is built.

## Test plan
- **Reset then stall-free pass.** NUM_INPUTS=784, RD_LATENCY=1, start at t=0 → mac_clear at 1; addresses 0..783 on 2..785; 784 mac_en pulses on 3..786; mac_last at 786; result_valid from 787.
- **Stall injection.** stall high for 5 cycles at address 100 and 3 cycles during DRAIN → feat_addr holds at 100; mac_en=0 while stalled; result_valid at 795. With macro defined, perf_stalls=8.
- **Result back-pressure.** result_ready held low for 20 cycles → result_valid stays high and busy=1; done pulses once, one cycle after result_ready rises.
- **Start while busy and back-to-back start.** start during RUN is ignored. start in the done cycle → mac_clear in the next cycle.
- **Reset mid-pass.** rst asserted at address 400 → all outputs 0 immediately, no done. A following start runs a full 784-address pass.
- **RD_LATENCY=3.** → first mac_en 3 cycles after address 0, DRAIN lasts 3 cycles, 784 enables in total.
